// File: rtl/eq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : eq_pkg
// Purpose : Shared definitions for the equation blocks: answer sequencer
//           state encoding, default widths/counts and the result-register
//           select encoding (0 = no register, 1..N = result register N).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package eq_pkg;

  localparam int c_data_w    = 4;  // answer / result register width
  localparam int c_n_ans     = 3;  // answers per round
  localparam int c_max_tries = 3;  // entry attempts per round

  // Result-register select: 0 means "nothing selected"
  localparam logic [1:0] c_rsel_none = 2'd0;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SOLVE      = 3'd1,
    ST_WAIT_SOLVE = 3'd2,
    ST_ENTER      = 3'd3,
    ST_COMPARE    = 3'd4,
    ST_CHECK      = 3'd5,
    ST_PASS       = 3'd6,
    ST_FAIL       = 3'd7
  } seq_state_t;

  // Answer index k (0-based) maps to result register k+1
  function automatic logic [1:0] rsel_of_idx(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage : eq_pkg
`default_nettype wire

// File: rtl/go_edge_sync.sv
`default_nettype none
// ============================================================================
// Module  : go_edge_sync
// Purpose : Brings an asynchronous key level into the clock domain with a
//           2-flop synchronizer and produces a single-cycle pulse on each
//           rising edge. A held key yields one pulse only.
// Ports   : Clock    - system clock, rising edge
//           Reset    - asynchronous active-high reset
//           async_in - raw key level
//           rise     - one-cycle pulse on synchronized rising edge
// Revision: 1.0 - initial release
// ============================================================================
module go_edge_sync (
  input  logic Clock,
  input  logic Reset,
  input  logic async_in,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= async_in;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  // Decoded purely from registers, so the pulse is glitch-free
  assign rise = r_sync & ~r_sync_d;

endmodule : go_edge_sync
`default_nettype wire

// File: rtl/answer_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : answer_sequencer
// Purpose : Round controller for an equation datapath. Launches one solve,
//           collects N_ANS answers (one per Go press), compares them with the
//           datapath result registers through a shared read port and reports
//           correct/wrong, allowing up to MAX_TRIES entry attempts.
// Ports   : Clock, Reset         - clock / async active-high reset
//           Go, data_in          - answer key and switch value
//           start                - begin a round (IDLE/PASS/FAIL only)
//           solve_start/done     - datapath handshake
//           rd_sel, rd_data      - result register read port
//           entry_idx            - index of next answer to enter
//           tries_left           - remaining attempts
//           busy, correct, wrong - round status
// Revision: 1.0 - initial release
// ============================================================================
module answer_sequencer
  import eq_pkg::*;
#(
  parameter int DATA_W    = c_data_w,
  parameter int N_ANS     = c_n_ans,
  parameter int MAX_TRIES = c_max_tries
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Go,
  input  logic [DATA_W-1:0] data_in,
  input  logic              start,
  output logic              solve_start,
  input  logic              solve_done,
  output logic [1:0]        rd_sel,
  input  logic [DATA_W-1:0] rd_data,
  output logic [1:0]        entry_idx,
  output logic [1:0]        tries_left,
  output logic              busy,
  output logic              correct,
  output logic              wrong
);

  localparam logic [1:0] c_last_idx   = 2'(N_ANS - 1);
  localparam logic [1:0] c_tries_init = 2'(MAX_TRIES);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [DATA_W-1:0] r_ans [N_ANS];
  logic [1:0]        r_entry_idx;
  logic [1:0]        r_cmp_idx;
  logic [1:0]        r_tries;
  logic              r_mismatch;
  logic              w_go_rise;
  logic              w_last_entry;
  logic              w_last_cmp;
  logic              w_rd_mismatch;

  go_edge_sync u_go_sync (
    .Clock    (Clock),
    .Reset    (Reset),
    .async_in (Go),
    .rise     (w_go_rise)
  );

  assign w_last_entry  = (r_entry_idx == c_last_idx);
  assign w_last_cmp    = (r_cmp_idx == c_last_idx);
  assign w_rd_mismatch = (rd_data != r_ans[r_cmp_idx]);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    solve_start = 1'b0;
    rd_sel      = c_rsel_none;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_SOLVE;
      end
      ST_SOLVE: begin
        solve_start = 1'b1;
        w_state_nxt = ST_WAIT_SOLVE;
      end
      ST_WAIT_SOLVE: begin
        if (solve_done) w_state_nxt = ST_ENTER;
      end
      ST_ENTER: begin
        if (w_go_rise && w_last_entry) w_state_nxt = ST_COMPARE;
      end
      ST_COMPARE: begin
        rd_sel = rsel_of_idx(r_cmp_idx);
        if (w_last_cmp) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        // Decision uses the pre-decrement count: one try left means the
        // decremented value is zero and the round is lost.
        if (!r_mismatch)          w_state_nxt = ST_PASS;
        else if (r_tries <= 2'd1) w_state_nxt = ST_FAIL;
        else                      w_state_nxt = ST_ENTER;
      end
      ST_PASS, ST_FAIL: begin
        if (start) w_state_nxt = ST_SOLVE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Answer storage, counters and mismatch accumulator
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N_ANS; i++) r_ans[i] <= '0;
      r_entry_idx <= 2'd0;
      r_cmp_idx   <= 2'd0;
      r_tries     <= 2'd0;
      r_mismatch  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (start) begin
            for (int i = 0; i < N_ANS; i++) r_ans[i] <= '0;
            r_entry_idx <= 2'd0;
            r_cmp_idx   <= 2'd0;
            r_tries     <= c_tries_init;
            r_mismatch  <= 1'b0;
          end
        end
        ST_ENTER: begin
          if (w_go_rise) begin
            r_ans[r_entry_idx] <= data_in;
            r_entry_idx        <= w_last_entry ? 2'd0 : r_entry_idx + 2'd1;
            r_cmp_idx          <= 2'd0;
          end
        end
        ST_COMPARE: begin
          // Full scan: every register is read even after a mismatch
          r_mismatch <= r_mismatch | w_rd_mismatch;
          r_cmp_idx  <= w_last_cmp ? 2'd0 : r_cmp_idx + 2'd1;
        end
        ST_CHECK: begin
          if (r_mismatch) begin
            if (r_tries != 2'd0) r_tries <= r_tries - 2'd1;
            r_entry_idx <= 2'd0;
            r_mismatch  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign entry_idx  = r_entry_idx;
  assign tries_left = r_tries;
  assign busy       = (r_state != ST_IDLE) && (r_state != ST_PASS) &&
                      (r_state != ST_FAIL);
  assign correct    = (r_state == ST_PASS);
  assign wrong      = (r_state == ST_FAIL);

endmodule : answer_sequencer
`default_nettype wire

// File: tb/tb_answer_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_answer_sequencer
// Purpose : Self-checking bench for answer_sequencer. Emulates the datapath
//           (result registers + solve handshake) and predicts each round's
//           outcome from the answer/result sets and the attempt count.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_answer_sequencer;

  localparam int DW = 4;
  localparam int NA = 3;
  localparam int MT = 3;

  logic          Clock      = 1'b0;
  logic          Reset      = 1'b0;
  logic          Go         = 1'b0;
  logic          start      = 1'b0;
  logic          solve_done = 1'b0;
  logic [DW-1:0] data_in    = '0;
  logic [DW-1:0] rd_data;
  logic          solve_start;
  logic [1:0]    rd_sel;
  logic [1:0]    entry_idx;
  logic [1:0]    tries_left;
  logic          busy;
  logic          correct;
  logic          wrong;

  int errors  = 0;
  int checks  = 0;
  int n_solve = 0;

  // Emulated datapath result registers 1..NA
  logic [DW-1:0] res_q [NA];

  // Round model: number of wrong attempts so far and whether a pass occurred
  int m_wrong;
  bit m_ok;
  int m_solve0;

  answer_sequencer #(.DATA_W(DW), .N_ANS(NA), .MAX_TRIES(MT)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Go          (Go),
    .data_in     (data_in),
    .start       (start),
    .solve_start (solve_start),
    .solve_done  (solve_done),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
    .entry_idx   (entry_idx),
    .tries_left  (tries_left),
    .busy        (busy),
    .correct     (correct),
    .wrong       (wrong)
  );

  always #5 Clock = ~Clock;

  always_comb begin
    rd_data = '0;
    if (rd_sel >= 2'd1 && rd_sel <= 2'd3) rd_data = res_q[rd_sel - 2'd1];
  end

  always @(posedge Clock) if (solve_start === 1'b1) n_solve <= n_solve + 1;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [DW-1:0] v);
    data_in = v;
    Go = 1'b1;
    tick(5);
    Go = 1'b0;
    tick(4);
  endtask

  task automatic set_res(input logic [DW-1:0] a, b, c);
    res_q[0] = a; res_q[1] = b; res_q[2] = c;
  endtask

  // From IDLE/PASS/FAIL into WAIT_SOLVE
  task automatic start_round();
    m_wrong  = 0;
    m_ok     = 0;
    m_solve0 = n_solve;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("solve_start_pulse", solve_start, 1);
    chk("tries_reload", tries_left, MT);
    tick();
    chk("solve_start_single", solve_start, 0);
    chk("busy_wait_solve", busy, 1);
  endtask

  // Datapath answers two cycles after solve_start
  task automatic finish_solve();
    tick();
    solve_done = 1'b1;
    tick();
    solve_done = 1'b0;
    chk("enter_busy", busy, 1);
    chk("enter_idx0", entry_idx, 0);
  endtask

  // One full entry attempt; expectation derived from the round rules
  task automatic attempt(input logic [DW-1:0] a0, a1, a2);
    logic [DW-1:0] av [NA];
    bit ok;
    av[0] = a0; av[1] = a1; av[2] = a2;
    ok = 1;
    for (int i = 0; i < NA; i++) begin
      press(av[i]);
      if (i < NA - 1) chk("entry_idx_step", entry_idx, i + 1);
      if (av[i] !== res_q[i]) ok = 0;
    end
    if (ok) m_ok = 1;
    else    m_wrong++;
    chk("att_correct", correct, m_ok);
    chk("att_wrong", wrong, (!m_ok && m_wrong == MT));
    chk("att_tries", tries_left, MT - m_wrong);
    chk("att_busy", busy, (!m_ok && m_wrong < MT));
    chk("att_entry_idx", entry_idx, 0);
    chk("att_one_solve", n_solve, m_solve0 + 1);
  endtask

  initial begin
    int s0;
    set_res(4'd0, 4'd0, 4'd0);

    // ---- reset state ----
    Reset = 1'b1;
    tick(2);
    chk("rst_solve_start", solve_start, 0);
    chk("rst_rd_sel", rd_sel, 0);
    chk("rst_entry_idx", entry_idx, 0);
    chk("rst_tries", tries_left, 0);
    chk("rst_flags", {busy, correct, wrong}, 0);
    Reset = 1'b0;
    tick(2);

    // ---- correct first try with exact compare timing ----
    set_res(4'd5, 4'd2, 4'd9);
    start_round();
    finish_solve();
    press(4'd5);
    press(4'd2);
    data_in = 4'd9;
    // short first pulse gets captured; the second rise lands in COMPARE
    Go = 1'b1; tick();
    Go = 1'b0; tick();
    Go = 1'b1; tick();
    chk("cmp0_rd_sel", rd_sel, 1);
    chk("cmp0_entry_idx", entry_idx, 0);
    tick();
    chk("cmp1_rd_sel", rd_sel, 2);
    tick();
    chk("cmp2_rd_sel", rd_sel, 3);
    tick();
    chk("check_rd_sel", rd_sel, 0);
    chk("check_busy", busy, 1);
    chk("check_correct", correct, 0);
    tick();
    chk("pass_correct", correct, 1);
    chk("pass_wrong", wrong, 0);
    chk("pass_busy", busy, 0);
    chk("pass_tries", tries_left, MT);
    Go = 1'b0;
    tick(4);
    chk("pass_no_capture", entry_idx, 0);
    press(4'd3);
    chk("pass_go_ignored", {correct, entry_idx}, 3'b100);

    // ---- retry path ----
    start_round();
    finish_solve();
    attempt(4'd5, 4'd3, 4'd9);
    attempt(4'd5, 4'd2, 4'd9);

    // ---- input hygiene ----
    set_res(4'd1, 4'd2, 4'd3);
    start_round();
    s0 = n_solve;
    press(4'd7);                       // during WAIT_SOLVE
    chk("wait_go_ignored", entry_idx, 0);
    chk("wait_still_busy", busy, 1);
    finish_solve();
    data_in = 4'd1;
    Go = 1'b1;
    tick(20);
    Go = 1'b0;
    tick(4);
    chk("held_go_once", entry_idx, 1);
    solve_done = 1'b1; tick(); solve_done = 1'b0; tick();
    chk("done_in_enter", {busy, entry_idx}, 3'b101);
    start = 1'b1; tick(); start = 1'b0; tick(2);
    chk("start_busy_ignored", {busy, entry_idx}, 3'b101);
    chk("start_busy_no_solve", n_solve, s0);
    press(4'd2);
    press(4'd3);
    chk("hygiene_correct", correct, 1);
    chk("hygiene_tries", tries_left, MT);

    // ---- reset mid-ENTER ----
    set_res(4'd5, 4'd2, 4'd9);
    start_round();
    finish_solve();
    press(4'd5);
    chk("pre_rst_idx", entry_idx, 1);
    Reset = 1'b1;
    tick();
    chk("midrst_outputs", {solve_start, rd_sel, entry_idx, tries_left, busy, correct, wrong}, 0);
    Reset = 1'b0;
    tick();
    start_round();
    finish_solve();
    attempt(4'd5, 4'd2, 4'd9);

    // ---- exhaustion ----
    start_round();
    finish_solve();
    attempt(4'd0, 4'd0, 4'd0);
    attempt(4'd0, 4'd0, 4'd0);
    attempt(4'd0, 4'd0, 4'd0);
    s0 = n_solve;
    start_round();
    tick(5);
    chk("fail_restart_one_solve", n_solve, s0 + 1);
    finish_solve();
    attempt(4'd5, 4'd2, 4'd9);

    // ---- width edge ----
    set_res(4'd15, 4'd0, 4'd15);
    start_round();
    finish_solve();
    attempt(4'd15, 4'd0, 4'd15);
    start_round();
    finish_solve();
    attempt(4'd15, 4'd0, 4'd14);
    attempt(4'd15, 4'd0, 4'd15);

    // ---- randomized rounds ----
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NA; i++) res_q[i] = 4'($urandom_range(0, 15));
      start_round();
      finish_solve();
      for (int a = 0; a < MT && !m_ok; a++) begin
        if ($urandom_range(0, 2) == 0)
          attempt(res_q[0], res_q[1], res_q[2]);
        else
          attempt(res_q[0] ^ 4'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), res_q[2]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_answer_sequencer
`default_nettype wire
